// File: rtl/bram_fill_sched_if.sv
// Channel-side bus of the BRAM fill scheduler: FIFO empty/pop pairs and the
// registered per-channel write commands towards the BRAM crossbar.
interface bram_fill_sched_if #(
    parameter int NUM_MC = 16,
    parameter int BW     = 9,
    parameter int AW     = 6
);
    logic [NUM_MC-1:0]    mcfifo_empty;
    logic [NUM_MC-1:0]    fifo_pop;
    logic [NUM_MC-1:0]    wr_valid;
    logic [NUM_MC*BW-1:0] wr_bank;
    logic [NUM_MC*AW-1:0] wr_addr;

    modport master (input mcfifo_empty, output fifo_pop, wr_valid, wr_bank, wr_addr);
    modport slave  (output mcfifo_empty, input fifo_pop, wr_valid, wr_bank, wr_addr);
endinterface

// File: rtl/bram_fill_sched.sv
// Load scheduler for the BRAM matrix: each channel walks banks round-robin, bank
// collisions go to a rotating-priority winner, full banks are skipped.
module bram_fill_sched #(
    parameter int NUM_MC   = 16,
    parameter int NUM_BANK = 420,
    parameter int DEPTH    = 64,
    parameter int BW       = 9,
    parameter int AW       = 6
) (
    input  logic              clk,
    input  logic              r_reset,
    input  logic              start,
    bram_fill_sched_if.master bus,
    output logic              busy,
    output logic              fill_done,
    output logic              err_unimpl
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int RRW = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
    localparam int FCW = $clog2(NUM_BANK + 1);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [FCW-1:0] ALL_FULL = FCW'(NUM_BANK);

    logic [1:0]           r_state;
    logic [BW-1:0]        r_ptr [NUM_MC];
    logic [AW:0]          r_cnt [NUM_BANK];
    logic [FCW-1:0]       r_full_cnt;
    logic [RRW-1:0]       r_rr_ptr;
    logic [NUM_MC-1:0]    r_wr_valid;
    logic [NUM_MC*BW-1:0] r_wr_bank;
    logic [NUM_MC*AW-1:0] r_wr_addr;
    logic                 r_err_unimpl;

    logic                 w_fill;
    logic [NUM_MC-1:0]    w_full_at;
    logic [NUM_MC-1:0]    w_req;
    logic [NUM_MC-1:0]    w_grant;
    logic [RRW-1:0]       w_prio [NUM_MC];
    logic [FCW-1:0]       w_new_full;
    logic [FCW-1:0]       w_full_cnt_nxt;

    function automatic logic [BW-1:0] f_next(input logic [BW-1:0] p);
        return (p == BW'(NUM_BANK - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_fill = (r_state == ST_FILL);

    // Priority rank 0 is the channel at r_rr_ptr; a lower rank wins a shared bank.
    always_comb begin
        for (int k = 0; k < NUM_MC; k++) begin
            w_prio[k]    = RRW'((k + NUM_MC - int'(r_rr_ptr)) % NUM_MC);
            w_full_at[k] = (r_cnt[r_ptr[k]] == CNT_FULL);
            w_req[k]     = w_fill && !bus.mcfifo_empty[k] && !w_full_at[k];
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_grant    = '0;
        w_new_full = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            w_grant[i] = w_req[i];
            for (int j = 0; j < NUM_MC; j++) begin
                if (j != i && w_req[j] && r_ptr[j] == r_ptr[i] && w_prio[j] < w_prio[i])
                    w_grant[i] = 1'b0;
            end
            if (w_grant[i] && r_cnt[r_ptr[i]] == CNT_LAST)
                w_new_full = w_new_full + 1'b1;
        end
    end

    assign w_full_cnt_nxt = r_full_cnt + w_new_full;

    always_ff @(posedge clk) begin
        if (r_reset) begin
            // NOTE: the bank counters are flops rather than a RAM, so they are cleared by reset like any other state.
            r_state      <= ST_IDLE;
            r_full_cnt   <= '0;
            r_rr_ptr     <= '0;
            r_wr_valid   <= '0;
            r_wr_bank    <= '0;
            r_wr_addr    <= '0;
            r_err_unimpl <= 1'b0;
            for (int i = 0; i < NUM_MC; i++)   r_ptr[i] <= BW'(i);
            for (int b = 0; b < NUM_BANK; b++) r_cnt[b] <= '0;
        end else begin
            r_wr_valid <= w_grant;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_FILL;
                        r_full_cnt <= '0;
                        r_rr_ptr   <= '0;
                        for (int i = 0; i < NUM_MC; i++)   r_ptr[i] <= BW'(i);
                        for (int b = 0; b < NUM_BANK; b++) r_cnt[b] <= '0;
                    end
                end
                ST_FILL: begin
                    if (start) r_err_unimpl <= 1'b1;
                    r_rr_ptr   <= (r_rr_ptr == RRW'(NUM_MC - 1)) ? '0 : r_rr_ptr + 1'b1;
                    r_full_cnt <= w_full_cnt_nxt;
                    // Going to DONE on the final grant edge puts its wr_valid in DONE.
                    if (w_full_cnt_nxt == ALL_FULL) r_state <= ST_DONE;
                    for (int i = 0; i < NUM_MC; i++) begin
                        if (w_grant[i]) begin
                            r_wr_bank[i*BW +: BW] <= r_ptr[i];
                            r_wr_addr[i*AW +: AW] <= r_cnt[r_ptr[i]][AW-1:0];
                            r_cnt[r_ptr[i]]       <= r_cnt[r_ptr[i]] + 1'b1;
                            r_ptr[i]              <= f_next(r_ptr[i]);
                        end else if (w_full_at[i]) begin
                            r_ptr[i] <= f_next(r_ptr[i]);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.fifo_pop = w_grant;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_bank  = r_wr_bank;
    assign bus.wr_addr  = r_wr_addr;
    assign busy         = w_fill;
    assign fill_done    = (r_state == ST_DONE);
    assign err_unimpl   = r_err_unimpl;
endmodule
